// File: rtl/wide_alu_serial.sv
// Limb-serial wide ALU (ADD/SUB/XOR/AND/OR, optional shift-add MUL) with a per-step slow-down factor.
// Define WIDE_ALU_SERIAL_MUL_EN to build the multiplier; otherwise opcode 2 is rejected like an invalid one.
module wide_alu_serial #(
  parameter int WIDTH   = 256,
  parameter int LIMB_W  = 32,
  parameter int DELAY_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trigger_i,
  input  logic                 clear_err_i,
  input  logic [WIDTH-1:0]     op_a_i,
  input  logic [WIDTH-1:0]     op_b_i,
  input  logic                 op_sel_we_i,
  input  logic [2:0]           op_sel_i,
  output logic [2:0]           op_sel_o,
  input  logic                 deaccel_factor_we_i,
  input  logic [DELAY_W-1:0]   deaccel_factor_i,
  output logic [DELAY_W-1:0]   deaccel_factor_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic [1:0]           status_o
);

  localparam int N     = WIDTH / LIMB_W;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;

`ifdef WIDE_ALU_SERIAL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q, acc_q, acc_next;
  logic [2:0]          run_op_q;
  logic [DELAY_W-1:0]  d_q, wait_q;
  logic [CNT_W-1:0]    step_q, last_idx;
  logic                carry_q;
  logic [LIMB_W-1:0]   a_limb, b_limb, limb_res;
  logic [LIMB_W:0]     limb_sum;
  logic                last_step;

  function automatic logic op_valid(input logic [2:0] op);
    return (op <= OP_OR) && (MUL_EN || op != OP_MUL);
  endfunction

  assign status_o = state_q;

  // SUB reuses the adder as a + ~b + 1; the +1 enters through the preset carry.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_limb = a_q[LIMB_W-1:0];
    b_limb = b_q[LIMB_W-1:0];
    if (run_op_q == OP_SUB) b_limb = ~b_limb;
    limb_sum = {1'b0, a_limb} + {1'b0, b_limb} + (LIMB_W+1)'(carry_q);
    limb_res = limb_sum[LIMB_W-1:0];
    case (run_op_q)
      OP_XOR:  limb_res = a_limb ^ b_limb;
      OP_AND:  limb_res = a_limb & b_limb;
      OP_OR:   limb_res = a_limb | b_limb;
      default: limb_res = limb_sum[LIMB_W-1:0];
    endcase
  end

  // Finished limbs enter at the top and drift down, so the LSB limb lands at bit 0.
  assign acc_next  = WIDTH'({limb_res, acc_q} >> LIMB_W);
  assign last_idx  = (run_op_q == OP_MUL) ? CNT_W'(WIDTH - 1) : CNT_W'(N - 1);
  assign last_step = (step_q == last_idx);

`ifdef WIDE_ALU_SERIAL_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, prod_q, prod_next;
  logic               accept, step_en;

  assign accept    = trigger_i && (state_q == ST_IDLE || state_q == ST_DONE) && op_valid(op_sel_o);
  assign step_en   = (state_q == ST_BUSY) && !trigger_i && (wait_q == '0);
  assign prod_next = prod_q + (b_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (accept) begin
      mcand_q <= {{WIDTH{1'b0}}, op_a_i};
      prod_q  <= '0;
    end else if (step_en && run_op_q == OP_MUL) begin
      mcand_q <= mcand_q << 1;
      prod_q  <= prod_next;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_sel_o         <= '0;
      deaccel_factor_o <= '0;
    end else begin
      if (op_sel_we_i)         op_sel_o         <= op_sel_i;
      if (deaccel_factor_we_i) deaccel_factor_o <= deaccel_factor_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      run_op_q <= OP_ADD;
      d_q      <= '0;
      wait_q   <= '0;
      step_q   <= '0;
      carry_q  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (trigger_i) begin
            if (op_valid(op_sel_o)) begin
              state_q  <= ST_BUSY;
              a_q      <= op_a_i;
              b_q      <= op_b_i;
              acc_q    <= '0;
              run_op_q <= op_sel_o;
              d_q      <= deaccel_factor_o;
              wait_q   <= deaccel_factor_o;
              step_q   <= '0;
              carry_q  <= (op_sel_o == OP_SUB);
            end else begin
              state_q <= ST_ERROR;
            end
          end
        end
        ST_BUSY: begin
          if (trigger_i) begin
            state_q <= ST_ERROR;
          end else if (wait_q != '0) begin
            wait_q <= wait_q - DELAY_W'(1);
          end else begin
            wait_q  <= d_q;
            step_q  <= step_q + CNT_W'(1);
            a_q     <= a_q >> LIMB_W;
            b_q     <= (run_op_q == OP_MUL) ? (b_q >> 1) : (b_q >> LIMB_W);
            carry_q <= limb_sum[LIMB_W];
            acc_q   <= acc_next;
            if (last_step) begin
              state_q <= ST_DONE;
              case (run_op_q)
                OP_ADD:  result_o <= {{(WIDTH-1){1'b0}}, limb_sum[LIMB_W], acc_next};
`ifdef WIDE_ALU_SERIAL_MUL_EN
                OP_MUL:  result_o <= prod_next;
`endif
                default: result_o <= {{WIDTH{1'b0}}, acc_next};
              endcase
            end
          end
        end
        ST_ERROR: begin
          if (clear_err_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
